// File: rtl/spike_pair_decoder.sv
// Receive-side decoder for LIF spike pulses: windowed firing rates, pre-neuron
// inter-spike interval, and signed pre/post timing differences for STDP.
module spike_pair_decoder #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 64,
  parameter int DT_MAX = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pre_spike,
  input  logic                    post_spike,
  input  logic                    clear,
  output logic [WIDTH-1:0]        rate_pre,
  output logic [WIDTH-1:0]        rate_post,
  output logic                    rate_valid,
  output logic [WIDTH-1:0]        isi_pre,
  output logic                    isi_valid,
  output logic signed [WIDTH-1:0] dt,
  output logic                    dt_valid
);

  // state     | meaning
  // IDLE      | no spike held, waiting for either neuron
  // PRE_SEEN  | pre spike held, t = cycles since it, waiting for post
  // POST_SEEN | post spike held, t = cycles since it, waiting for pre
  typedef enum logic [1:0] {IDLE, PRE_SEEN, POST_SEEN} state_t;

  localparam int                WW       = $clog2(WINDOW);
  localparam logic [WW-1:0]     WIN_LAST = WW'(WINDOW - 1);
  localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]  T_MAX    = WIDTH'(DT_MAX);
  localparam logic [WIDTH-1:0]  ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + ONE : v;
  endfunction

  logic [WW-1:0]    win_cnt;
  logic [WIDTH-1:0] cnt_pre, cnt_post;
  logic             isi_armed;
  logic [WIDTH-1:0] isi_cnt;
  state_t           state, state_nx;
  logic [WIDTH-1:0] t, t_nx;
  logic             dt_fire;
  logic signed [WIDTH-1:0] dt_nx;

  // The window-end cycle's own spikes are folded into the latched rate so the
  // restarted counters never see them twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt    <= '0;
      cnt_pre    <= '0;
      cnt_post   <= '0;
      rate_pre   <= '0;
      rate_post  <= '0;
      rate_valid <= 1'b0;
    end else if (clear) begin
      win_cnt    <= '0;
      cnt_pre    <= '0;
      cnt_post   <= '0;
      rate_pre   <= '0;
      rate_post  <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        win_cnt    <= '0;
        rate_pre   <= sat_inc(cnt_pre, pre_spike);
        rate_post  <= sat_inc(cnt_post, post_spike);
        rate_valid <= 1'b1;
        cnt_pre    <= '0;
        cnt_post   <= '0;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        cnt_pre  <= sat_inc(cnt_pre, pre_spike);
        cnt_post <= sat_inc(cnt_post, post_spike);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      isi_armed <= 1'b0;
      isi_cnt   <= '0;
      isi_pre   <= '0;
      isi_valid <= 1'b0;
    end else if (clear) begin
      isi_armed <= 1'b0;
      isi_cnt   <= '0;
      isi_pre   <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (pre_spike) begin
        isi_armed <= 1'b1;
        isi_cnt   <= ONE;
        if (isi_armed) begin
          isi_pre   <= isi_cnt;
          isi_valid <= 1'b1;
        end
      end else if (isi_armed) begin
        isi_cnt <= sat_inc(isi_cnt, 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      t        <= '0;
      dt       <= '0;
      dt_valid <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      t        <= '0;
      dt       <= '0;
      dt_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      t        <= t_nx;
      dt_valid <= dt_fire;
      if (dt_fire) dt <= dt_nx;
    end
  end

  // A partner arriving on the timeout cycle still pairs; only a silent
  // t==DT_MAX cycle drops the held spike.
  always_comb begin
    state_nx = state;
    t_nx     = t + ONE;
    dt_fire  = 1'b0;
    dt_nx    = '0;
    case (state)
      IDLE: begin
        t_nx = '0;
        if (pre_spike && post_spike) begin
          dt_fire = 1'b1;
        end else if (pre_spike) begin
          state_nx = PRE_SEEN;
          t_nx     = ONE;
        end else if (post_spike) begin
          state_nx = POST_SEEN;
          t_nx     = ONE;
        end
      end
      PRE_SEEN: begin
        if (post_spike) begin
          dt_fire = 1'b1;
          dt_nx   = t;
          if (pre_spike) begin
            t_nx = ONE;
          end else begin
            state_nx = IDLE;
            t_nx     = '0;
          end
        end else if (pre_spike) begin
          t_nx = ONE;
        end else if (t == T_MAX) begin
          state_nx = IDLE;
          t_nx     = '0;
        end
      end
      POST_SEEN: begin
        if (pre_spike) begin
          dt_fire = 1'b1;
          dt_nx   = '0 - t;
          if (post_spike) begin
            t_nx = ONE;
          end else begin
            state_nx = IDLE;
            t_nx     = '0;
          end
        end else if (post_spike) begin
          t_nx = ONE;
        end else if (t == T_MAX) begin
          state_nx = IDLE;
          t_nx     = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        t_nx     = '0;
      end
    endcase
  end

endmodule

// File: doc/spike_pair_decoder.md
# spike_pair_decoder

Receive-side decoder for the neuron spike outputs. It consumes the 1-cycle `pre_spike` / `post_spike` pulses produced by a pair of LIF neurons. From them it recovers three quantities:
- per-window firing rates,
- the pre-neuron inter-spike interval,
- signed pre/post spike-timing differences (the quantity the STDP synapse acts on).

Outputs are registered numeric values with valid strobes, suitable for driving `uio_out` or a host readout mux.

## Interface
- `WIDTH`, 8: width of every count, interval and timing output.
- `WINDOW`, 64: rate-window length in cycles; range 2..65535.
- `DT_MAX`, 100: pairing timeout in cycles; range 1..2^(WIDTH-1)-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pre_spike`  in  1  pre-neuron spike pulse, sampled every cycle.
- `post_spike`  in  1  post-neuron spike pulse, sampled every cycle.
- `clear`  in  1  synchronous clear; same effect as reset, one cycle.
- `rate_pre`  out  WIDTH  pre spikes counted in the last completed window.
- `rate_post`  out  WIDTH  post spikes counted in the last completed window.
- `rate_valid`  out  1  1-cycle pulse when rates update.
- `isi_pre`  out  WIDTH  cycles between the last two pre spikes.
- `isi_valid`  out  1  1-cycle pulse when `isi_pre` updates.
- `dt`  out  WIDTH signed  post time minus pre time, in cycles.
- `dt_valid`  out  1  1-cycle pulse when `dt` updates.

## Operation
- Reset/clear: all outputs 0; all counters 0; FSM in IDLE; ISI armed flag cleared. `clear` has priority over spike inputs in the same cycle.
- Rate window:
  - `win_cnt` runs 0..WINDOW-1 and wraps.
  - Per-neuron counters saturate at 2^WIDTH-1.
  - On the `win_cnt==WINDOW-1` cycle, count + that cycle's spike is latched into `rate_*` and `rate_valid` is pulsed.
  - Counters restart at 0, so no spike is lost or double-counted.
- ISI:
  - The first pre spike after reset/clear only arms the timer; no `isi_valid`.
  - Each later pre spike loads `isi_pre` with the cycles since the previous pre (saturating at 2^WIDTH-1) and pulses `isi_valid`.
- Pairing FSM, states IDLE, PRE_SEEN, POST_SEEN; timer `t` counts cycles since the held spike:
  - IDLE + pre only: go to PRE_SEEN, t<=1.
  - IDLE + post only: go to POST_SEEN, t<=1.
  - IDLE + both: dt<=0, pulse `dt_valid`, stay IDLE.
  - PRE_SEEN + post: dt<=+t, pulse `dt_valid`.
    - If pre also arrives that cycle: PRE_SEEN, t<=1 (new pre held).
    - Otherwise: go to IDLE.
  - PRE_SEEN + pre only: nearest-neighbour restart; t<=1, no output.
  - POST_SEEN mirrors PRE_SEEN with roles swapped; it emits dt<=-t.
  - Timeout: in PRE_SEEN/POST_SEEN with no partner and t==DT_MAX, go to IDLE with no output. A partner arriving in that same cycle still pairs (dt=±DT_MAX).
  - Otherwise t<=t+1 each cycle.
- Arithmetic: `dt` is two's complement and always lies in -DT_MAX..+DT_MAX, so it never overflows. Rate counters and ISI saturate; they never wrap.

## Timing
- All outputs are registered. The value and its valid pulse appear together in the cycle after the spike/window-end cycle that caused them, and valid is high for exactly 1 cycle.
- Value outputs hold until the next update, reset or clear.
- Latency is fixed at 1 cycle; there is no backpressure; inputs are accepted every cycle.
- `reset_n` asserted mid-window or mid-pair aborts immediately. After release, the first window is a full WINDOW cycles and no stale dt is emitted.
- A spike on the same cycle as `clear` is discarded.

## Test plan
- Rate: WINDOW=64; pre pulses at cycles 0,8,…,56; no post -> at cycle 64, rate_pre=8, rate_post=0, rate_valid pulsed exactly once; repeats every 64 cycles.
- Causal pair: pre at cycle 10, post at cycle 15 -> dt=+5 with dt_valid at cycle 16; FSM back in IDLE.
- Anti-causal and simultaneous: post at 20, pre at 23 -> dt=-3 (0xFD). Then pre and post both at 40 -> dt=0, one dt_valid only.
- Restart and timeout (DT_MAX=100): pre at 0, pre at 4, post at 9 -> single dt=+5. Pre at 200 with no post -> no dt_valid, IDLE by cycle 301. Post at 400 -> no pairing with that pre.
- ISI saturation: pre at 0, pre at 300 -> isi_pre=255, isi_valid at 301; no isi_valid at cycle 1.
- Reset/clear: assert reset_n low at cycle 30 of a window holding 5 counted spikes and a pending pre. After release, all outputs are 0, the next rate_valid comes exactly WINDOW cycles later, and no dt is emitted from the pre-reset spike. Repeat the same check with `clear`.
